video_timing_gen: RTL

//  Parametrised raster timing generator and pixel-stream sequencer. Drives the video_bus

---
 rtl/video_timing_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, region decode and a
// registered output stage that pulls pixels from a valid/ready source.
module video_timing_gen #(
    parameter int DATA_W = 32,
    parameter int HTOTAL = 800,
    parameter int HVIS = 640,
    parameter int HFP = 16,
    parameter int HSW = 96,
    parameter int VTOTAL = 525,
    parameter int VVIS = 480,
    parameter int VFP = 10,
    parameter int VSW = 2,
    parameter int HBORDER = 0,
    parameter int VBORDER = 0,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter logic [DATA_W-1:0] BORDER_COLOR = '0,
    parameter logic [DATA_W-1:0] UF_COLOR = '0,
    localparam int HW = $clog2(HTOTAL),
    localparam int VW = $clog2(VTOTAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              border,
    output logic [DATA_W-1:0] data,
    output logic              frame_start,
    output logic              underflow,
    input  logic              uf_clr,
    output logic [HW-1:0]     hpos,
    output logic [VW-1:0]     vpos
);

    logic [HW-1:0] hctr;
    logic [VW-1:0] vctr;
    logic [31:0]   hc;
    logic [31:0]   vc;
    logic          vis;
    logic          bord;
    logic          disp;
    logic          hs_act;
    logic          vs_act;
    logic          xfer;
    logic          hwrap;
    logic          vwrap;

    assign hc = 32'(hctr);
    assign vc = 32'(vctr);
    assign hwrap = (hc == HTOTAL - 1);
    assign vwrap = (vc == VTOTAL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hctr <= '0;
            vctr <= '0;
        end else if (!en) begin
            hctr <= '0;
            vctr <= '0;
        end else if (hwrap) begin
            hctr <= '0;
            vctr <= vwrap ? '0 : vctr + 1'b1;
        end else begin
            hctr <= hctr + 1'b1;
        end
    end

    // Border zone is carved out of the visible window; with zero border widths
    // both edge comparisons are false so border never asserts.
    assign vis  = (hc < HVIS) && (vc < VVIS);
    assign bord = vis && ((hc < HBORDER) || (hc >= HVIS - HBORDER) ||
                          (vc < VBORDER) || (vc >= VVIS - VBORDER));
    assign disp = vis && !bord;

    assign hs_act = (hc >= HVIS + HFP) && (hc < HVIS + HFP + HSW);
    assign vs_act = (vc >= VVIS + VFP) && (vc < VVIS + VFP + VSW);

    assign pix_ready = en && disp;
    assign xfer      = pix_valid && pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            blank       <= 1'b1;
            border      <= 1'b0;
            data        <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            blank       <= 1'b1;
            border      <= 1'b0;
            data        <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            blank       <= ~vis;
            border      <= bord;
            frame_start <= (hctr == '0) && (vctr == '0);
            if (xfer)
                data <= pix_data;
            else if (bord)
                data <= BORDER_COLOR;
            else if (disp)
                data <= UF_COLOR;
            else
                data <= '0;
        end
    end

    // A starved display slot is flagged but the source is not advanced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underflow <= 1'b0;
        else if (disp && en && !pix_valid)
            underflow <= 1'b1;
        else if (uf_clr)
            underflow <= 1'b0;
    end

    assign hpos = hctr;
    assign vpos = vctr;

endmodule
